// File: rtl/hsync_decoder.sv
// Locks onto the hbl_n/h_sync_n line timing and recovers the active column index once locked.
// Latency 1 clk from input change to every output; no backpressure, outputs are free-running.

module hsync_decoder #(
  parameter int LINE_LEN   = 65,
  parameter int ACTIVE_LEN = 40,
  parameter int SYNC_OFS   = 5,
  parameter int SYNC_LEN   = 10,
  parameter int LOCK_LINES = 4,
  parameter int CNT_W      = 7
) (
  input  logic             clk,
  input  logic             mr_n,
  input  logic             hbl_n,
  input  logic             h_sync_n,
  output logic [5:0]       col,
  output logic             col_valid,
  output logic             line_strobe,
  output logic             locked,
  output logic             err_period,
  output logic             err_sync,
  output logic [CNT_W-1:0] line_len_meas
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LINE_C    = CNT_W'(LINE_LEN);
  localparam logic [CNT_W-1:0] ACT_C     = CNT_W'(ACTIVE_LEN);
  localparam logic [CNT_W-1:0] OFS_C     = CNT_W'(SYNC_OFS);
  localparam logic [CNT_W-1:0] SW_C      = CNT_W'(SYNC_LEN);
  localparam logic [5:0]       COL_LAST  = 6'(ACTIVE_LEN - 1);
  localparam logic [2:0]       GOOD_LAST = 3'(LOCK_LINES - 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  state_t           state, state_nxt;
  logic [2:0]       good, good_nxt;
  logic             hbl_q, sync_q;
  logic [CNT_W-1:0] per, act, ofs_cnt, ofs_meas, swid;
  logic [1:0]       nsync;
  logic             bad_line;
  logic             hbl_rise, hbl_fall, sync_fall, fault;
  logic             per_ok, sync_ok;
  logic             timeout, period_err, sync_err, strobe_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Edges compare the value sampled on this edge against the previous sample.
  assign hbl_rise  = hbl_n & ~hbl_q;
  assign hbl_fall  = ~hbl_n & hbl_q;
  assign sync_fall = ~h_sync_n & sync_q;
  assign fault     = (state != ST_SEARCH) && hbl_n && !h_sync_n;
  assign per_ok    = (per == LINE_C) && (act == ACT_C);
  assign sync_ok   = (ofs_meas == OFS_C) && (swid == SW_C) && (nsync == 2'd1) && !bad_line;

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      state <= ST_SEARCH;
      good  <= '0;
    end else begin
      state <= state_nxt;
      good  <= good_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    good_nxt   = good;
    timeout    = 1'b0;
    period_err = 1'b0;
    sync_err   = 1'b0;
    strobe_nxt = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (hbl_rise) begin
          state_nxt = ST_MEASURE;
          good_nxt  = '0;
        end
      end
      ST_MEASURE, ST_LOCKED: begin
        if (hbl_rise) begin
          if (per_ok && sync_ok) begin
            if (state == ST_LOCKED) begin
              strobe_nxt = 1'b1;
            end else if (good == GOOD_LAST) begin
              state_nxt = ST_LOCKED;
              good_nxt  = '0;
            end else begin
              good_nxt = good + 3'd1;
            end
          end else begin
            state_nxt  = ST_MEASURE;
            good_nxt   = '0;
            period_err = !per_ok;
            sync_err   = !sync_ok;
          end
        end else if (per == CNT_MAX - 1'b1) begin
          // per saturates on this edge: the line has no plausible end.
          timeout   = 1'b1;
          state_nxt = ST_SEARCH;
          good_nxt  = '0;
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      hbl_q         <= 1'b1;
      sync_q        <= 1'b1;
      per           <= '0;
      act           <= '0;
      ofs_cnt       <= '0;
      ofs_meas      <= '0;
      swid          <= '0;
      nsync         <= '0;
      bad_line      <= 1'b0;
      col           <= '0;
      col_valid     <= 1'b0;
      line_strobe   <= 1'b0;
      locked        <= 1'b0;
      err_period    <= 1'b0;
      err_sync      <= 1'b0;
      line_len_meas <= '0;
    end else begin
      hbl_q   <= hbl_n;
      sync_q  <= h_sync_n;
      per     <= hbl_rise ? CNT_W'(1) : sat_inc(per);
      act     <= hbl_rise ? CNT_W'(1) : (hbl_n ? sat_inc(act) : act);
      ofs_cnt <= hbl_fall ? CNT_W'(1) : (!hbl_n ? sat_inc(ofs_cnt) : ofs_cnt);
      swid    <= sync_fall ? CNT_W'(1) : (!h_sync_n ? sat_inc(swid) : swid);

      if (hbl_rise)       ofs_meas <= '0;
      else if (sync_fall) ofs_meas <= hbl_fall ? '0 : ofs_cnt;

      if (hbl_rise)                        nsync <= {1'b0, sync_fall};
      else if (sync_fall && nsync != 2'd3) nsync <= nsync + 2'd1;

      bad_line <= hbl_rise ? fault : (bad_line | fault);

      line_strobe <= strobe_nxt;
      locked      <= (state_nxt == ST_LOCKED);
      err_period  <= period_err | timeout;
      err_sync    <= sync_err | fault;

      if (timeout)                              line_len_meas <= CNT_MAX;
      else if (hbl_rise && state != ST_SEARCH)  line_len_meas <= per;

      // Column tracking covers the line on which lock is first declared.
      if (hbl_rise && state_nxt == ST_LOCKED) begin
        col       <= '0;
        col_valid <= 1'b1;
      end else if (state_nxt != ST_LOCKED || !hbl_n) begin
        col_valid <= 1'b0;
      end else if (col_valid && col != COL_LAST) begin
        col <= col + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_hsync_decoder.sv
// Drives whole lines with chosen timing; a line-level reference predicts every output cycle by cycle.

module tb_hsync_decoder;

  localparam int SEARCH  = 0;
  localparam int MEASURE = 1;
  localparam int LOCKED  = 2;

  logic       clk = 1'b0;
  logic       mr_n, hbl_n, h_sync_n;
  logic [5:0] col;
  logic       col_valid, line_strobe, locked, err_period, err_sync;
  logic [6:0] line_len_meas;

  always #5 clk = ~clk;

  hsync_decoder dut (
    .clk(clk), .mr_n(mr_n), .hbl_n(hbl_n), .h_sync_n(h_sync_n),
    .col(col), .col_valid(col_valid), .line_strobe(line_strobe), .locked(locked),
    .err_period(err_period), .err_sync(err_sync), .line_len_meas(line_len_meas)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [17:0] exp_q[$];
  int          m_st, m_good, m_lmeas, m_col;
  bit          m_colv;
  int          prev_len, prev_act, line_no;
  bit          prev_sync_ok;

  function automatic logic [17:0] obs_vec();
    return {locked, col_valid, col, line_strobe, err_period, err_sync, line_len_meas};
  endfunction

  function automatic logic [17:0] pack(bit lk, bit cv, int c, bit st, bit ep, bit es, int lm);
    return {lk, cv, 6'(c), st, ep, es, 7'(lm)};
  endfunction

  // Fields: {locked, col_valid, col[5:0], line_strobe, err_period, err_sync, line_len_meas[6:0]}
  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic drive_cycle(input logic h, input logic s, input logic r,
                             input logic [17:0] e, input string tag);
    @(negedge clk);
    hbl_n    = h;
    h_sync_n = s;
    if (!r && mr_n) begin
      mr_n = 1'b0;
      #1;
      check_eq({tag, ".async_rst"}, obs_vec(), 18'h0);
    end
    mr_n = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_eq(tag, obs_vec(), exp_q.pop_front());
  endtask

  task automatic model_reset();
    m_st    = SEARCH;
    m_good  = 0;
    m_lmeas = 0;
    m_col   = 0;
    m_colv  = 0;
  endtask

  // One line: act clocks high, then blank clocks low; sync low for sw clocks starting
  // ofs clocks into blank; optional one-clock sync glitch at active cycle glitch;
  // optional 3-clock reset starting at cycle rst_at.
  task automatic run_line(input int act, input int blank, input int ofs, input int sw,
                          input int glitch, input int rst_at);
    int len;
    bit h, s, r, st, ep, es;
    len = act + blank;
    line_no++;
    for (int k = 0; k < len; k++) begin
      h  = (k < act);
      s  = !((k >= act + ofs && k < act + ofs + sw) || k == glitch);
      r  = !(rst_at >= 0 && k >= rst_at && k < rst_at + 3);
      st = 0; ep = 0; es = 0;
      if (!r) begin
        model_reset();
      end else if (k == 0) begin
        if (m_st == SEARCH) begin
          m_st   = MEASURE;
          m_good = 0;
        end else begin
          m_lmeas = prev_len;
          if (prev_len == 65 && prev_act == 40 && prev_sync_ok) begin
            if (m_st == LOCKED) st = 1;
            else begin
              m_good++;
              if (m_good == 4) m_st = LOCKED;
            end
          end else begin
            ep     = (prev_len != 65 || prev_act != 40);
            es     = !prev_sync_ok;
            m_st   = MEASURE;
            m_good = 0;
          end
        end
        if (m_st == LOCKED) begin
          m_col  = 0;
          m_colv = 1;
        end else m_colv = 0;
      end else begin
        if (m_st != SEARCH && k == glitch) es = 1;
        if (m_st != SEARCH && k == 126) begin
          ep      = 1;
          m_st    = SEARCH;
          m_good  = 0;
          m_lmeas = 127;
        end
        if (!h || m_st != LOCKED) m_colv = 0;
        else if (m_colv && m_col < 39) m_col++;
      end
      drive_cycle(h, s, r, pack(m_st == LOCKED, m_colv, m_col, st, ep, es, m_lmeas),
                  $sformatf("line%0d.k%0d", line_no, k));
    end
    prev_len     = len;
    prev_act     = act;
    prev_sync_ok = (ofs == 5 && sw == 10 && glitch < 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    mr_n = 1'b0; hbl_n = 1'b1; h_sync_n = 1'b1;
    line_no = 0; prev_len = 0; prev_act = 0; prev_sync_ok = 0;
    model_reset();

    for (int i = 0; i < 6; i++)
      drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 18'h0, "reset");
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b0, 1'b1, 1'b1, 18'h0, "preamble");

    repeat (6) run_line(40, 25, 5, 10, -1, -1);   // lock, then one strobed line
    run_line(40, 26, 5, 10, -1, -1);              // 66-clock period
    repeat (5) run_line(40, 25, 5, 10, -1, -1);   // relock
    run_line(40, 25, 5, 9, -1, -1);               // short sync
    run_line(40, 25, 5, 10, 10, -1);              // sync glitch inside active
    repeat (5) run_line(40, 25, 5, 10, -1, -1);
    run_line(200, 25, 5, 10, -1, -1);             // hbl_n stuck high: timeout
    repeat (5) run_line(40, 25, 5, 10, -1, -1);
    run_line(40, 25, 5, 10, -1, 20);              // reset mid-line while locked
    repeat (6) run_line(40, 25, 5, 10, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
